// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU control path.
// Holds the FSM state encoding, opcode/funct constants, the 3-bit ALU
// operation codes (also used by the ALU), the ALU decode mode and the
// control-word payload driven by multicycle_control.
package cpu_pkg;

    localparam int unsigned STATE_W   = 4;
    localparam int unsigned OP_W      = 6;
    localparam int unsigned FUNCT_W   = 6;
    localparam int unsigned ALU_SEL_W = 3;

    // FSM state encoding, also visible on the debug state port
    localparam logic [STATE_W-1:0] ST_FETCH     = 4'd0;
    localparam logic [STATE_W-1:0] ST_DECODE    = 4'd1;
    localparam logic [STATE_W-1:0] ST_EXEC_R    = 4'd2;
    localparam logic [STATE_W-1:0] ST_EXEC_I    = 4'd3;
    localparam logic [STATE_W-1:0] ST_ALU_WB    = 4'd4;
    localparam logic [STATE_W-1:0] ST_MEM_ADDR  = 4'd5;
    localparam logic [STATE_W-1:0] ST_MEM_READ  = 4'd6;
    localparam logic [STATE_W-1:0] ST_MEM_WB    = 4'd7;
    localparam logic [STATE_W-1:0] ST_MEM_WRITE = 4'd8;
    localparam logic [STATE_W-1:0] ST_BRANCH    = 4'd9;
    localparam logic [STATE_W-1:0] ST_JUMP      = 4'd10;

    // Opcodes (instruction[31:26])
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;

    // R-type funct codes (instruction[5:0])
    localparam logic [FUNCT_W-1:0] F_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] F_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] F_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] F_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] F_XOR = 6'b100110;
    localparam logic [FUNCT_W-1:0] F_NOR = 6'b100111;
    localparam logic [FUNCT_W-1:0] F_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [ALU_SEL_W-1:0] ALU_AND  = 3'b000;
    localparam logic [ALU_SEL_W-1:0] ALU_OR   = 3'b001;
    localparam logic [ALU_SEL_W-1:0] ALU_ADD  = 3'b010;
    localparam logic [ALU_SEL_W-1:0] ALU_ZERO = 3'b011;
    localparam logic [ALU_SEL_W-1:0] ALU_NOR  = 3'b100;
    localparam logic [ALU_SEL_W-1:0] ALU_XOR  = 3'b101;
    localparam logic [ALU_SEL_W-1:0] ALU_SUB  = 3'b110;
    localparam logic [ALU_SEL_W-1:0] ALU_SLT  = 3'b111;

    // How the ALU operation is chosen in the current state
    typedef enum logic [2:0] {
        ALU_MODE_NONE  = 3'd0,
        ALU_MODE_ADD   = 3'd1,
        ALU_MODE_SUB   = 3'd2,
        ALU_MODE_FUNCT = 3'd3,
        ALU_MODE_IMM   = 3'd4
    } alu_mode_e;

    // Datapath control word
    typedef struct packed {
        logic [ALU_SEL_W-1:0] alu_sel;
        logic                 alu_src_a;
        logic [1:0]           alu_src_b;
        logic                 pc_write;
        logic                 pc_write_cond;
        logic [1:0]           pc_src;
        logic                 iord;
        logic                 mem_read;
        logic                 mem_write;
        logic                 ir_write;
        logic                 reg_write;
        logic                 reg_dst;
        logic                 mem_to_reg;
        logic                 illegal;
    } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decoder.
// Ports: mode (how to pick the op), opcode, funct -> alu_sel (3-bit ALU op),
//        illegal (unsupported R-type funct in FUNCT mode).
module alu_decoder
    import cpu_pkg::*;
(
    input  alu_mode_e            mode,
    input  logic [OP_W-1:0]      opcode,
    input  logic [FUNCT_W-1:0]   funct,
    output logic [ALU_SEL_W-1:0] alu_sel,
    output logic                 illegal
);

    // Map mode plus instruction fields to an ALU operation
    always_comb begin
        alu_sel = '0;
        illegal = 1'b0;
        case (mode)
            ALU_MODE_ADD: alu_sel = ALU_ADD;
            ALU_MODE_SUB: alu_sel = ALU_SUB;
            ALU_MODE_FUNCT: begin
                case (funct)
                    F_ADD:   alu_sel = ALU_ADD;
                    F_SUB:   alu_sel = ALU_SUB;
                    F_AND:   alu_sel = ALU_AND;
                    F_OR:    alu_sel = ALU_OR;
                    F_XOR:   alu_sel = ALU_XOR;
                    F_NOR:   alu_sel = ALU_NOR;
                    F_SLT:   alu_sel = ALU_SLT;
                    default: begin
                        alu_sel = ALU_ZERO;
                        illegal = 1'b1;
                    end
                endcase
            end
            ALU_MODE_IMM: begin
                // Unsupported opcodes never reach EXEC_I; zero-out is a safe fill
                case (opcode)
                    OP_ADDI: alu_sel = ALU_ADD;
                    OP_ANDI: alu_sel = ALU_AND;
                    OP_ORI:  alu_sel = ALU_OR;
                    OP_SLTI: alu_sel = ALU_SLT;
                    default: alu_sel = ALU_ZERO;
                endcase
            end
            default: alu_sel = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-style datapath.
// Inputs : clk, rst_n (async, active-low), opcode, funct, zero, memReady.
// Outputs: aluSel, aluSrcA, aluSrcB, pcWrite, pcWriteCond, pcSrc, iorD,
//          memRead, memWrite, irWrite, regWrite, regDst, memToReg,
//          illegal (one-cycle pulse), state (debug).
// Controls are decoded from the registered state (plus memReady/opcode/funct
// where the instruction flow needs them) and forced to 0 while rst_n is low.
module multicycle_control
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OP_W-1:0]      opcode,
    input  logic [FUNCT_W-1:0]   funct,
    input  logic                 zero,
    input  logic                 memReady,
    output logic [ALU_SEL_W-1:0] aluSel,
    output logic                 aluSrcA,
    output logic [1:0]           aluSrcB,
    output logic                 pcWrite,
    output logic                 pcWriteCond,
    output logic [1:0]           pcSrc,
    output logic                 iorD,
    output logic                 memRead,
    output logic                 memWrite,
    output logic                 irWrite,
    output logic                 regWrite,
    output logic                 regDst,
    output logic                 memToReg,
    output logic                 illegal,
    output logic [STATE_W-1:0]   state
);

    logic [STATE_W-1:0]   state_q;
    logic [STATE_W-1:0]   state_d;
    logic                 rtype_q;
    alu_mode_e            alu_mode;
    logic [ALU_SEL_W-1:0] dec_alu_sel;
    logic                 dec_illegal;
    ctrl_t                ctrl;

    // zero only qualifies pcWriteCond in the datapath's PC-enable logic
    logic unused_zero;
    assign unused_zero = zero;

    // State register; regDst source is captured while the opcode is decoded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            rtype_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                rtype_q <= (opcode == OP_RTYPE);
            end
        end
    end

    // ALU selection mode depends on state only, keeping the decoder loop-free
    always_comb begin
        alu_mode = ALU_MODE_NONE;
        case (state_q)
            ST_FETCH, ST_DECODE, ST_MEM_ADDR: alu_mode = ALU_MODE_ADD;
            ST_EXEC_R:                        alu_mode = ALU_MODE_FUNCT;
            ST_EXEC_I:                        alu_mode = ALU_MODE_IMM;
            ST_BRANCH:                        alu_mode = ALU_MODE_SUB;
            default:                          alu_mode = ALU_MODE_NONE;
        endcase
    end

    alu_decoder u_alu_decoder (
        .mode    (alu_mode),
        .opcode  (opcode),
        .funct   (funct),
        .alu_sel (dec_alu_sel),
        .illegal (dec_illegal)
    );

    // Next-state and control decode
    always_comb begin
        state_d      = state_q;
        ctrl         = '0;
        ctrl.alu_sel = dec_alu_sel;
        case (state_q)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                if (memReady) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    state_d       = ST_DECODE;
                end
            end
            ST_DECODE: begin
                ctrl.alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:                         state_d = ST_EXEC_R;
                    OP_LW, OP_SW:                     state_d = ST_MEM_ADDR;
                    OP_BEQ:                           state_d = ST_BRANCH;
                    OP_J:                             state_d = ST_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = ST_EXEC_I;
                    default: begin
                        ctrl.illegal = 1'b1;
                        state_d      = ST_FETCH;
                    end
                endcase
            end
            ST_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.illegal   = dec_illegal;
                state_d        = dec_illegal ? ST_FETCH : ST_ALU_WB;
            end
            ST_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                state_d        = ST_ALU_WB;
            end
            ST_ALU_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = rtype_q;
                state_d        = ST_FETCH;
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                state_d        = (opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
            end
            ST_MEM_READ: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
                if (memReady) begin
                    state_d = ST_MEM_WB;
                end
            end
            ST_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                state_d         = ST_FETCH;
            end
            ST_MEM_WRITE: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
                if (memReady) begin
                    state_d = ST_FETCH;
                end
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = 2'b01;
                state_d            = ST_FETCH;
            end
            ST_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = 2'b10;
                state_d       = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
        // Reset must silence every control immediately, without a clock edge
        if (!rst_n) begin
            ctrl = '0;
        end
    end

    assign aluSel      = ctrl.alu_sel;
    assign aluSrcA     = ctrl.alu_src_a;
    assign aluSrcB     = ctrl.alu_src_b;
    assign pcWrite     = ctrl.pc_write;
    assign pcWriteCond = ctrl.pc_write_cond;
    assign pcSrc       = ctrl.pc_src;
    assign iorD        = ctrl.iord;
    assign memRead     = ctrl.mem_read;
    assign memWrite    = ctrl.mem_write;
    assign irWrite     = ctrl.ir_write;
    assign regWrite    = ctrl.reg_write;
    assign regDst      = ctrl.reg_dst;
    assign memToReg    = ctrl.mem_to_reg;
    assign illegal     = ctrl.illegal;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: directed instruction scenarios plus a
// randomized instruction stream. Expected per-cycle controls are built from
// per-instruction phase sequences and checked at every falling edge.
module tb_multicycle_control;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       memReady;
    logic [2:0] aluSel;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic       pcWrite;
    logic       pcWriteCond;
    logic [1:0] pcSrc;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regWrite;
    logic       regDst;
    logic       memToReg;
    logic       illegal;
    logic [3:0] state;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .memReady    (memReady),
        .aluSel      (aluSel),
        .aluSrcA     (aluSrcA),
        .aluSrcB     (aluSrcB),
        .pcWrite     (pcWrite),
        .pcWriteCond (pcWriteCond),
        .pcSrc       (pcSrc),
        .iorD        (iorD),
        .memRead     (memRead),
        .memWrite    (memWrite),
        .irWrite     (irWrite),
        .regWrite    (regWrite),
        .regDst      (regDst),
        .memToReg    (memToReg),
        .illegal     (illegal),
        .state       (state)
    );

    logic [21:0] dut_vec;
    assign dut_vec = {state, aluSel, aluSrcA, aluSrcB, pcWrite, pcWriteCond, pcSrc,
                      iorD, memRead, memWrite, irWrite, regWrite, regDst, memToReg, illegal};

    typedef struct packed {
        logic [21:0] vec;
        logic        chk_eff;
        logic        eff;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   run_len = 0;
    int   last_len = 0;
    logic [3:0] prev_st = 4'd0;
    logic [5:0] r_functs [0:6];
    logic [5:0] i_ops [0:3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [21:0] mk(input logic [3:0] st, input logic [2:0] alu,
                                       input logic sa, input logic [1:0] sb,
                                       input logic pw, input logic pwc, input logic [1:0] ps,
                                       input logic io, input logic mr, input logic mw,
                                       input logic irw, input logic rw, input logic rd,
                                       input logic m2r, input logic ill);
        return {st, alu, sa, sb, pw, pwc, ps, io, mr, mw, irw, rw, rd, m2r, ill};
    endfunction

    // 0 R, 1 lw, 2 sw, 3 beq, 4 j, 5 I-type, 6 unsupported
    function automatic int op_class(input logic [5:0] op);
        case (op)
            6'b000000: return 0;
            6'b100011: return 1;
            6'b101011: return 2;
            6'b000100: return 3;
            6'b000010: return 4;
            6'b001000, 6'b001100, 6'b001101, 6'b001010: return 5;
            default:   return 6;
        endcase
    endfunction

    // {legal, aluSel} for an R-type funct
    function automatic logic [3:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 4'b1_010;
            6'b100010: return 4'b1_110;
            6'b100100: return 4'b1_000;
            6'b100101: return 4'b1_001;
            6'b100110: return 4'b1_101;
            6'b100111: return 4'b1_100;
            6'b101010: return 4'b1_111;
            default:   return 4'b0_011;
        endcase
    endfunction

    function automatic logic [2:0] i_alu(input logic [5:0] op);
        case (op)
            6'b001000: return 3'b010;
            6'b001100: return 3'b000;
            6'b001101: return 3'b001;
            default:   return 3'b111;
        endcase
    endfunction

    function automatic logic [21:0] v_fetch(input logic done);
        return mk(ST_FETCH, 3'b010, 1'b0, 2'b01, done, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, done, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [21:0] v_memaddr();
        return mk(ST_MEM_ADDR, 3'b010, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [21:0] v_memwrite();
        return mk(ST_MEM_WRITE, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [21:0] v_decode(input logic ill);
        return mk(ST_DECODE, 3'b010, 1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ill);
    endfunction

    // Drive one cycle of inputs and queue the controls that cycle must show
    task automatic step(input logic [21:0] v, input logic mr, input logic [5:0] op,
                        input logic [5:0] fn, input logic z, input logic ce);
        exp_t e;
        opcode   = op;
        funct    = fn;
        memReady = mr;
        zero     = z;
        e.vec     = v;
        e.chk_eff = ce;
        e.eff     = z;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // One full instruction: fw fetch stalls, mw data-memory stalls
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fw, input int mw);
        int         cls;
        logic [3:0] ra;
        for (int i = 0; i < fw; i++)
            step(v_fetch(1'b0), 1'b0, 6'($urandom), 6'($urandom), 1'($urandom), 1'b0);
        step(v_fetch(1'b1), 1'b1, 6'($urandom), 6'($urandom), 1'($urandom), 1'b0);
        cls = op_class(op);
        step(v_decode(cls == 6), 1'($urandom), op, fn, 1'($urandom), 1'b0);
        case (cls)
            0: begin
                ra = r_alu(fn);
                step(mk(ST_EXEC_R, ra[2:0], 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ~ra[3]),
                     1'($urandom), op, fn, 1'($urandom), 1'b0);
                if (ra[3])
                    step(mk(ST_ALU_WB, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0),
                         1'($urandom), op, fn, 1'($urandom), 1'b0);
            end
            5: begin
                step(mk(ST_EXEC_I, i_alu(op), 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
                     1'($urandom), op, fn, 1'($urandom), 1'b0);
                step(mk(ST_ALU_WB, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0),
                     1'($urandom), op, fn, 1'($urandom), 1'b0);
            end
            1: begin
                step(v_memaddr(), 1'($urandom), op, fn, 1'($urandom), 1'b0);
                for (int i = 0; i <= mw; i++)
                    step(mk(ST_MEM_READ, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
                         (i == mw), op, fn, 1'($urandom), 1'b0);
                step(mk(ST_MEM_WB, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0),
                     1'($urandom), op, fn, 1'($urandom), 1'b0);
            end
            2: begin
                step(v_memaddr(), 1'($urandom), op, fn, 1'($urandom), 1'b0);
                for (int i = 0; i <= mw; i++)
                    step(v_memwrite(), (i == mw), op, fn, 1'($urandom), 1'b0);
            end
            3: step(mk(ST_BRANCH, 3'b110, 1'b1, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
                    1'($urandom), op, fn, z, 1'b1);
            4: step(mk(ST_JUMP, 3'b000, 1'b0, 2'b00, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
                    1'($urandom), op, fn, 1'($urandom), 1'b0);
            default: ;
        endcase
    endtask

    // Holds FETCH one idle cycle and checks the DUT's own instruction length
    task automatic check_len(input string nm, input int lit);
        memReady = 1'b0;
        last_len = -1;
        @(negedge clk);
        #1;
        chk(nm, 32'(last_len), 32'(lit));
        @(posedge clk);
        #1;
    endtask

    // Per-cycle comparison against the queued expectation
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            chk("cycle_ctrl", 32'(dut_vec), 32'(cur.vec));
            if (cur.chk_eff)
                chk("pc_eff_write", 32'(pcWrite | (pcWriteCond & zero)), 32'(cur.eff));
        end
    end

    // Instruction length seen on the DUT: completing fetch plus non-FETCH cycles
    always @(negedge clk) begin
        if (!rst_n) begin
            run_len = 0;
        end else if (state == ST_FETCH) begin
            if (prev_st != ST_FETCH) last_len = run_len;
            run_len = irWrite ? 1 : 0;
        end else begin
            run_len++;
        end
        prev_st = state;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        r_functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010};
        i_ops    = '{6'b001000, 6'b001100, 6'b001101, 6'b001010};

        rst_n = 1'b0; memReady = 1'b1; opcode = 6'b100011; funct = 6'd0; zero = 1'b1;
        #3;
        chk("reset_outputs", 32'(dut_vec), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hold", 32'(dut_vec), 32'd0);
        rst_n = 1'b1;

        run_instr(6'b000000, 6'b100000, 1'b0, 0, 0);  check_len("len_add", 4);
        run_instr(6'b100011, 6'b000000, 1'b0, 0, 3);  check_len("len_lw_wait3", 8);
        run_instr(6'b101011, 6'b000000, 1'b0, 0, 0);  check_len("len_sw", 4);
        run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);  check_len("len_beq_taken", 3);
        run_instr(6'b000100, 6'b000000, 1'b0, 0, 0);  check_len("len_beq_not_taken", 3);
        run_instr(6'b000010, 6'b000000, 1'b0, 0, 0);  check_len("len_j", 3);
        run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);  check_len("len_illegal_op", 2);
        run_instr(6'b000000, 6'b000001, 1'b0, 0, 0);  check_len("len_illegal_funct", 3);
        run_instr(6'b001010, 6'b010101, 1'b0, 0, 0);  check_len("len_slti", 4);
        run_instr(6'b001101, 6'b110011, 1'b0, 2, 0);  check_len("len_ori", 4);

        // Asynchronous reset in the middle of a stalled store
        step(v_fetch(1'b1), 1'b1, 6'd0, 6'd0, 1'b0, 1'b0);
        step(v_decode(1'b0), 1'b0, 6'b101011, 6'd0, 1'b0, 1'b0);
        step(v_memaddr(), 1'b0, 6'b101011, 6'd0, 1'b0, 1'b0);
        step(v_memwrite(), 1'b0, 6'b101011, 6'd0, 1'b0, 1'b0);
        step(v_memwrite(), 1'b0, 6'b101011, 6'd0, 1'b0, 1'b0);
        memReady = 1'b0;
        #1;
        chk("sw_wait_memwrite", 32'(memWrite), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_memwrite", 32'(memWrite), 32'd0);
        chk("rst_async_outputs", 32'(dut_vec), 32'd0);
        memReady = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_hold", 32'(dut_vec), 32'd0);
        rst_n = 1'b1;
        run_instr(6'b000000, 6'b100010, 1'b0, 0, 0);  check_len("len_after_reset", 4);

        for (int k = 0; k < 400; k++) begin
            fn = 6'($urandom);
            case ($urandom_range(0, 9))
                0, 1: begin
                    op = 6'b000000;
                    if ($urandom_range(0, 3) != 0) fn = r_functs[$urandom_range(0, 6)];
                end
                2:       op = 6'b100011;
                3:       op = 6'b101011;
                4:       op = 6'b000100;
                5:       op = 6'b000010;
                6, 7:    op = i_ops[$urandom_range(0, 3)];
                8: begin
                    op = 6'($urandom);
                    while (op_class(op) != 6) op = 6'($urandom);
                end
                default: op = 6'($urandom);
            endcase
            run_instr(op, fn, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 opcode  input  6  instruction[31:26], valid once IR is loaded.
REQ-004 funct  input  6  instruction[5:0], used only when opcode=000000.
REQ-005 zero  input  1  ALU zero flag, sampled in BRANCH.
REQ-006 memReady  input  1  memory handshake; access completes in a cycle with memReady=1.
REQ-007 aluSel  output  3  ALU operation: AND 000, OR 001, ADD 010, NOR 100, XOR 101, SUB 110, SLT 111, zero-out 011.
REQ-008 aluSrcA  output  1  0=PC, 1=register A.
REQ-009 aluSrcB  output  2  00=reg B, 01=constant 4, 10=sign-extended imm, 11=imm<<2.
REQ-010 pcWrite, pcWriteCond, pcSrc[1:0]  outputs  PC update control; pcSrc 00=ALU, 01=ALUOut, 10=jump target.
REQ-011 iorD, memRead, memWrite, irWrite  outputs  1 each  memory/IR control.
REQ-012 regWrite, regDst, memToReg  outputs  1 each  register-file writeback control.
REQ-013 illegal  output  1  one-cycle pulse on an unsupported opcode/funct.
REQ-014 state  output  4  current state, for debug.

Function
REQ-015 Moore FSM: every output SHALL be a pure function of the registered state, except pcWriteCond gating (REQ-023); all unlisted outputs are 0.
REQ-016 States: FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH, JUMP.
REQ-017 FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluSel=010, pcSrc=00.
- irWrite and pcWrite are asserted only in the cycle memReady=1; the FSM then moves to DECODE.
- Otherwise the FSM holds in FETCH.
REQ-018 DECODE: aluSrcA=0, aluSrcB=11, aluSel=010 (branch target precompute); next state by opcode:
- 000000 -> EXEC_R
- 100011/101011 (lw/sw) -> MEM_ADDR
- 000100 (beq) -> BRANCH
- 000010 (j) -> JUMP
- 001000/001100/001101/001010 (addi/andi/ori/slti) -> EXEC_I
- anything else -> FETCH with illegal=1 for one cycle
REQ-019 EXEC_R: aluSrcA=1, aluSrcB=00, aluSel from funct:
- 100000->010, 100010->110, 100100->000, 100101->001, 100110->101, 100111->100, 101010->111
- any other funct: aluSel=011, illegal=1, next state FETCH with no writeback
REQ-020 EXEC_I: aluSrcA=1, aluSrcB=10, aluSel by opcode: addi 010, andi 000, ori 001, slti 111; next state ALU_WB.
REQ-021 ALU_WB: regWrite=1, memToReg=0; regDst=1 for R-type, 0 for I-type (latched at DECODE); next state FETCH.
REQ-022 MEM_ADDR: aluSrcA=1, aluSrcB=10, aluSel=010; next state MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: iorD=1, memRead=1; holds until memReady=1, then MEM_WB.
- MEM_WB: regWrite=1, memToReg=1, regDst=0; next state FETCH.
- MEM_WRITE: iorD=1, memWrite=1; holds until memReady=1, then FETCH.
REQ-023 BRANCH: aluSrcA=1, aluSrcB=00, aluSel=110, pcWriteCond=1, pcSrc=01; effective PC write = zero; next state FETCH.
REQ-024 JUMP: pcWrite=1, pcSrc=10; next state FETCH.
REQ-025 Cycle counts with memReady=1 in every memory cycle: R/I-type 4, lw 5, sw 4, beq 3, j 3.
REQ-026 While waiting on memReady, memRead/memWrite and iorD SHALL stay stable; irWrite/pcWrite stay 0 until the completing cycle.
REQ-027 opcode/funct SHALL be ignored outside DECODE, EXEC_R, EXEC_I and MEM_ADDR.

Reset
REQ-028 rst_n=0 SHALL force state=FETCH and all control outputs to 0 immediately, regardless of clk, including mid-instruction and mid-memory-wait.
REQ-029 On the first rising edge after rst_n deasserts, the FSM evaluates FETCH normally; no partial write completes across reset.

Structure
REQ-030 Shared package cpu_pkg SHALL hold the state encoding, opcode/funct constants and 3-bit ALU operation codes, which the ALU also uses.
REQ-031 Sub-module alu_decoder (combinational: funct/opcode/mode -> aluSel, illegal) SHALL be instantiated once.

Verification
REQ-032 add (opcode 000000, funct 100000), memReady=1: states FETCH,DECODE,EXEC_R,ALU_WB; aluSel=010 in EXEC_R; regWrite=1, regDst=1 in ALU_WB only.
REQ-033 lw with memReady held low 3 cycles in MEM_READ: 8 cycles total; memRead=1, iorD=1 stable throughout; regWrite=1, memToReg=1 in MEM_WB.
REQ-034 beq with zero=1, then zero=0: pcWriteCond=1, aluSel=110 in BRANCH both times; effective PC write only in the first; 3 cycles each.
REQ-035 opcode 111111, then R-type funct 000001: illegal pulses one cycle each; returns to FETCH; regWrite never asserted.
REQ-036 rst_n low asynchronously mid-MEM_WRITE: memWrite drops without a clock edge; after release the FSM starts at FETCH.
REQ-037 slti and ori: aluSel=111 and 001 in EXEC_I; aluSrcB=10; regDst=0 in ALU_WB.
